rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multi-cycle control unit for the RV32I core. It replaces the per-format combinational decoders with one sequencer that steps each instruction through fetch, decode, execute, memory and writeback states. It drives PC, ALU-select and register/memory write enables with a memory ready handshake. It sits between the instruction register and the datapath, and adds a memory-timeout fault, a retired-instruction counter and an optional illegal-opcode trap.

## Interface
- `TIMEOUT_W`, default 8: width of the memory-wait counter. A fault is raised after 2^TIMEOUT_W−1 consecutive not-ready cycles.
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `CLK` in 1: processor clock. Everything is sampled on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `INSN` in 32: instruction-register contents. Valid from DECODE onward.
- `mem_ready` in 1: memory completes the current request this cycle.
- `branch_taken` in 1: branch comparator result for the current INSN.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, valid with `mem_req`.
- `addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result.
- `ir_we` out 1: load INSN register.
- `pc_we` out 1: update PC.
- `rd_we` out 1: register-file write enable. This is an enable, not a gated clock.
- `pc_next_sel` out 1: next-PC source. 0 = PC adder, 1 = ALU result.
- `pc_alu_sel` out 1: PC adder operand. 0 = +4, 1 = +immediate.
- `sub_sra` out 1: ALU subtract / arithmetic-shift select.
- `fault` out 1: sticky memory-timeout flag.
- `illegal` out 1: sticky illegal-opcode flag. Tied 0 unless the trap is compiled in.
- `instret` out INSTRET_W: count of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - Drives `mem_req=1`, `addr_sel=0`.
  - On `mem_ready`: `ir_we=1`, go to DECODE.
- **DECODE** (1 cycle). Next state by opcode:
  - JAL / JALR → WB.
  - All others → EXEC.
- **EXEC** (1 cycle). Next state by opcode:
  - OP, OP-IMM, LUI, AUIPC → WB.
  - LOAD, STORE → MEM.
  - BRANCH: `pc_we=1`, `pc_next_sel=0`, `pc_alu_sel=branch_taken`, go to FETCH.
  - MISC-MEM, SYSTEM: `pc_we=1` (+4), go to FETCH.
- **MEM**
  - Drives `mem_req=1`, `addr_sel=1`, `mem_we` = (opcode==STORE).
  - On `mem_ready`, LOAD → WB.
  - On `mem_ready`, STORE: `pc_we=1` (+4), go to FETCH.
- **WB** (1 cycle). `rd_we=1`, `pc_we=1`, then go to FETCH. PC source by opcode:
  - JAL: `pc_alu_sel=1`, `pc_next_sel=0`.
  - JALR: `pc_next_sel=1`, `pc_alu_sel=0`, `sub_sra=0`.
  - All other opcodes: `pc_next_sel=0`, `pc_alu_sel=0`.
- **`sub_sra`** is 1 only in EXEC, in two cases:
  - OP with INSN[30]=1 (SUB, SRA).
  - OP-IMM with funct3=101 and INSN[30]=1 (SRAI).
- **Wait counter**
  - Counts consecutive FETCH/MEM cycles with `mem_ready`=0.
  - Clears on `mem_ready` and on leaving FETCH/MEM.
  - Reaching all-ones: go to HALT, set `fault`.
- **HALT**
  - All strobes 0, `fault` held.
  - Left only by `RST`.
- **`instret`** increments by 1 on every cycle with `pc_we=1` and wraps modulo 2^INSTRET_W.
- Strobes not listed for a state are 0.

## Timing
- Outputs are decoded combinationally from registered state and INSN. There is no output register.
- **Reset**
  - While `RST`=1: all outputs 0, `instret`=0, `fault`=`illegal`=0, wait counter 0.
  - State register is loaded with FETCH.
  - First `mem_req` appears in the first cycle after `RST` falls.
- **`RST` mid-instruction** (including mid-MEM store) aborts it. No `pc_we`, `rd_we` or `mem_we` is asserted in the cycle after `RST` is sampled.
- **Latency with zero-wait memory:**
  - OP/OP-IMM/LUI/AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - JAL/JALR: 3 cycles.
  - Each memory wait cycle adds 1.
- **`mem_ready`** is ignored outside FETCH/MEM.
- **`mem_req` and `mem_we`** hold stable until the `mem_ready` cycle and drop the cycle after it.

## Configuration
- `RV_CTRL_ILLEGAL_TRAP_EN` defined:
  - An opcode outside the RV32I base set, seen in DECODE, goes to HALT.
  - Sets `illegal` with no strobes. `illegal` stays set until `RST`.
- `RV_CTRL_ILLEGAL_TRAP_EN` undefined:
  - Unknown opcodes behave as a NOP: EXEC with `pc_we` (+4), then FETCH.
  - `illegal` is tied 0.

## Structure
- Package `rv_ctrl_pkg` holds:
  - Opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM.
  - State enum.
  - `addr_sel`, `pc_next_sel` and `pc_alu_sel` encodings.
- Sub-module `rv_insn_class`: combinational opcode-to-class decoder with a `legal` output. The FSM, wait counter and `instret` stay in the top module.

## Test plan
- ADD (0x002081B3), `mem_ready` tied 1:
  - FETCH, DECODE, EXEC, WB in 4 cycles.
  - `rd_we`=1 and `pc_we`=1 only in WB.
  - `sub_sra`=0; `instret` 0→1.
- SUB / SRAI (0x402081B3 / 0x4020D193): `sub_sra`=1 in EXEC only.
- LW with `mem_ready` low 3 cycles in MEM:
  - `mem_req`=1 with `addr_sel`=1 for 4 cycles.
  - WB in cycle 8.
- BEQ with `branch_taken`=1, then a second BEQ with `branch_taken`=0:
  - `pc_alu_sel`=1 on the first, 0 on the second.
  - 3 cycles each.
- JALR (0x000080E7): WB asserts `rd_we`, `pc_we`, `pc_next_sel`=1, `pc_alu_sel`=0.
- `mem_ready` held 0 in FETCH (TIMEOUT_W=8):
  - `fault`=1 after 255 cycles and all strobes 0.
  - `RST` pulse clears it and restarts FETCH.
- With `RV_CTRL_ILLEGAL_TRAP_EN`, INSN=0x0000007F:
  - `illegal`=1, state HALT.
- With `RV_CTRL_ILLEGAL_TRAP_EN` undefined, same INSN:
  - PC+4 taken, `instret`+1.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM states,
// instruction classes and datapath select encodings.
package rv_ctrl_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_NOP,
        CLS_UNKNOWN
    } insn_class_e;

    localparam logic ADDR_PC    = 1'b0;
    localparam logic ADDR_ALU   = 1'b1;
    localparam logic PCN_ADDER  = 1'b0;
    localparam logic PCN_ALU    = 1'b1;
    localparam logic PCA_FOUR   = 1'b0;
    localparam logic PCA_IMM    = 1'b1;

    // SUB/SRA (OP) and SRAI (OP-IMM, funct3=101) share INSN[30] as the alternate-op bit.
    function automatic logic alu_alt(input logic [6:0] opcode, input logic [2:0] funct3,
                                     input logic bit30);
        return bit30 && ((opcode == OP) || ((opcode == OP_IMM) && (funct3 == 3'b101)));
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Memory request/ready handshake between the controller (master) and memory (slave).
interface rv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/rv_multicycle_ctrl_insn_class.sv
// Combinational opcode-to-class decoder; legal flags the eleven RV32I base opcodes.
module rv_insn_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output insn_class_e cls,
    output logic        legal
);

    always_comb begin
        cls   = CLS_UNKNOWN;
        legal = 1'b1;
        case (opcode)
            OP, OP_IMM, LUI, AUIPC: cls = CLS_ALU;
            LOAD:                   cls = CLS_LOAD;
            STORE:                  cls = CLS_STORE;
            BRANCH:                 cls = CLS_BRANCH;
            JAL:                    cls = CLS_JAL;
            JALR:                   cls = CLS_JALR;
            MISC_MEM, SYSTEM:       cls = CLS_NOP;
            default: begin
                cls   = CLS_UNKNOWN;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle sequencer with memory-timeout fault and retired-instruction counter.
// Optional illegal-opcode trap compiled in with `define RV_CTRL_ILLEGAL_TRAP_EN.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int INSTRET_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          INSN,
    input  logic                 branch_taken,
    rv_multicycle_ctrl_if.master mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 rd_we,
    output logic                 pc_next_sel,
    output logic                 pc_alu_sel,
    output logic                 sub_sra,
    output logic                 fault,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = WAIT_MAX - TIMEOUT_W'(1);

    state_e                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   wait_q, wait_d;
    logic                   fault_q;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   set_fault;

    insn_class_e            cls;
    logic                   legal;
    logic                   insn_unused;

    logic c_mem_req, c_mem_we, c_addr_sel, c_ir_we, c_pc_we, c_rd_we;
    logic c_pc_next_sel, c_pc_alu_sel, c_sub_sra;

    rv_insn_class u_class (
        .opcode (INSN[6:0]),
        .cls    (cls),
        .legal  (legal)
    );

    assign insn_unused = ^{INSN[31], INSN[29:15], INSN[11:7]};

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic set_illegal;
`endif

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        set_fault     = 1'b0;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        set_illegal   = 1'b0;
`endif
        c_mem_req     = 1'b0;
        c_mem_we      = 1'b0;
        c_addr_sel    = ADDR_PC;
        c_ir_we       = 1'b0;
        c_pc_we       = 1'b0;
        c_rd_we       = 1'b0;
        c_pc_next_sel = PCN_ADDER;
        c_pc_alu_sel  = PCA_FOUR;
        c_sub_sra     = 1'b0;

        case (state_q)
            FETCH: begin
                c_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    c_ir_we = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = HALT;
                    set_fault = 1'b1;
                end else begin
                    wait_d = wait_q + TIMEOUT_W'(1);
                end
            end

            DECODE: begin
                if (!legal) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                    state_d     = HALT;
                    set_illegal = 1'b1;
`else
                    state_d = EXEC;
`endif
                end else if (cls == CLS_JAL || cls == CLS_JALR) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                c_sub_sra = alu_alt(INSN[6:0], INSN[14:12], INSN[30]);
                case (cls)
                    CLS_ALU:              state_d = WB;
                    CLS_LOAD, CLS_STORE:  state_d = MEM;
                    CLS_BRANCH: begin
                        c_pc_we      = 1'b1;
                        c_pc_alu_sel = branch_taken ? PCA_IMM : PCA_FOUR;
                        state_d      = FETCH;
                    end
                    // Fences, system ops and (without the trap) unknown opcodes retire as NOPs.
                    default: begin
                        c_pc_we = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end

            MEM: begin
                c_mem_req  = 1'b1;
                c_addr_sel = ADDR_ALU;
                c_mem_we   = (cls == CLS_STORE);
                if (mem.mem_ready) begin
                    if (cls == CLS_STORE) begin
                        c_pc_we = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = HALT;
                    set_fault = 1'b1;
                end else begin
                    wait_d = wait_q + TIMEOUT_W'(1);
                end
            end

            WB: begin
                c_rd_we = 1'b1;
                c_pc_we = 1'b1;
                state_d = FETCH;
                if (cls == CLS_JAL) begin
                    c_pc_alu_sel = PCA_IMM;
                end else if (cls == CLS_JALR) begin
                    c_pc_next_sel = PCN_ALU;
                end
            end

            HALT: state_d = HALT;

            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (set_fault) begin
                fault_q <= 1'b1;
            end
            if (c_pc_we) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            illegal_q <= 1'b0;
        end else if (set_illegal) begin
            illegal_q <= 1'b1;
        end
    end
    assign illegal = !RST && illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Reset forces every output low combinationally, not just from the next edge.
    assign mem.mem_req  = !RST && c_mem_req;
    assign mem.mem_we   = !RST && c_mem_we;
    assign mem.addr_sel = !RST && c_addr_sel;
    assign ir_we        = !RST && c_ir_we;
    assign pc_we        = !RST && c_pc_we;
    assign rd_we        = !RST && c_rd_we;
    assign pc_next_sel  = !RST && c_pc_next_sel;
    assign pc_alu_sel   = !RST && c_pc_alu_sel;
    assign sub_sra      = !RST && c_sub_sra;
    assign fault        = !RST && fault_q;
    assign instret      = RST ? '0 : instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: one expected record per retiring instruction.
module tb_rv_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] INSN = 32'h0;
    logic        branch_taken = 1'b0;
    logic        ir_we, pc_we, rd_we, pc_next_sel, pc_alu_sel, sub_sra, fault, illegal;
    logic [31:0] instret;

    rv_multicycle_ctrl_if bus ();

    rv_multicycle_ctrl #(.TIMEOUT_W(8), .INSTRET_W(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .INSN         (INSN),
        .branch_taken (branch_taken),
        .mem          (bus),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rd_we        (rd_we),
        .pc_next_sel  (pc_next_sel),
        .pc_alu_sel   (pc_alu_sel),
        .sub_sra      (sub_sra),
        .fault        (fault),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  cyc;
        logic        rd_we;
        logic        pcn;
        logic        pca;
        logic [3:0]  n_sub;
        logic [3:0]  sub_at;
        logic [3:0]  n_rdwe;
        logic [3:0]  n_mema;
        logic [3:0]  n_memwe;
        logic [31:0] instret;
    } rec_t;

    rec_t  sb[$];
    string nm_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    n_ret = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4020D193;
    localparam logic [31:0] I_ADDI  = 32'h40008093;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_SW    = 32'h0010A023;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    function automatic logic [31:0] strobes();
        return {23'd0, bus.mem_req, bus.mem_we, bus.addr_sel, ir_we, pc_we, rd_we,
                pc_next_sel, pc_alu_sel, sub_sra};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        end
    endtask

    // Expected instret is the bench's own retire count since the last reset.
    task automatic expect_retire(input string nm, input int cyc, input bit rd, input bit pcn,
                                 input bit pca, input int nsub, input int sub_at,
                                 input int nrdwe, input int nmema, input int nmemwe);
        rec_t r;
        r.cyc     = 8'(cyc);
        r.rd_we   = rd;
        r.pcn     = pcn;
        r.pca     = pca;
        r.n_sub   = 4'(nsub);
        r.sub_at  = 4'(sub_at);
        r.n_rdwe  = 4'(nrdwe);
        r.n_mema  = 4'(nmema);
        r.n_memwe = 4'(nmemwe);
        r.instret = 32'(n_ret);
        n_ret++;
        sb.push_back(r);
        nm_q.push_back(nm);
    endtask

    // Called in FETCH, just after an edge; drives mem_ready until the instruction retires.
    task automatic run_insn(input logic [31:0] insn, input logic bt, input int fstall,
                            input int mstall);
        int fs;
        int ms;
        bit done;
        fs = fstall;
        ms = mstall;
        done = 1'b0;
        INSN = insn;
        branch_taken = bt;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.mem_req && !bus.addr_sel && fs > 0) begin
                bus.mem_ready = 1'b0;
                fs--;
            end else if (bus.mem_req && bus.addr_sel && ms > 0) begin
                bus.mem_ready = 1'b0;
                ms--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            done = pc_we;
            @(posedge CLK);
            #1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL run_timeout insn=0x%08h: got no pc_we within 40 cycles, required retire", insn);
        end
    endtask

    initial begin : monitor
        int   cyc;
        int   nsub;
        int   subat;
        int   nrdwe;
        int   nmema;
        int   nmemwe;
        rec_t got;
        rec_t exp;
        string nm;
        cyc = 0; nsub = 0; subat = 0; nrdwe = 0; nmema = 0; nmemwe = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                cyc = 0; nsub = 0; subat = 0; nrdwe = 0; nmema = 0; nmemwe = 0;
            end else begin
                cyc++;
                if (sub_sra) begin
                    nsub++;
                    subat = cyc;
                end
                if (rd_we) nrdwe++;
                if (bus.mem_req && bus.addr_sel) nmema++;
                if (bus.mem_we) nmemwe++;
                if (pc_we) begin
                    got.cyc     = 8'(cyc);
                    got.rd_we   = rd_we;
                    got.pcn     = pc_next_sel;
                    got.pca     = pc_alu_sel;
                    got.n_sub   = 4'(nsub);
                    got.sub_at  = 4'(subat);
                    got.n_rdwe  = 4'(nrdwe);
                    got.n_mema  = 4'(nmema);
                    got.n_memwe = 4'(nmemwe);
                    got.instret = instret;
                    tests_run++;
                    if (sb.size() == 0) begin
                        tests_failed++;
                        $display("FAIL retire_unexpected: got retire at cycle %0d, required none", cyc);
                    end else begin
                        exp = sb.pop_front();
                        nm  = nm_q.pop_front();
                        if (got !== exp) begin
                            tests_failed++;
                            $display("FAIL %s: got cyc=%0d rd_we=%0b pcn=%0b pca=%0b sub=%0d@%0d rdwe=%0d mema=%0d memwe=%0d instret=%0d; required cyc=%0d rd_we=%0b pcn=%0b pca=%0b sub=%0d@%0d rdwe=%0d mema=%0d memwe=%0d instret=%0d",
                                     nm, got.cyc, got.rd_we, got.pcn, got.pca, got.n_sub, got.sub_at,
                                     got.n_rdwe, got.n_mema, got.n_memwe, got.instret,
                                     exp.cyc, exp.rd_we, exp.pcn, exp.pca, exp.n_sub, exp.sub_at,
                                     exp.n_rdwe, exp.n_mema, exp.n_memwe, exp.instret);
                        end
                    end
                    cyc = 0; nsub = 0; subat = 0; nrdwe = 0; nmema = 0; nmemwe = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        bus.mem_ready = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_strobes", strobes(), 32'h0);
        check("reset_flags", {30'd0, fault, illegal}, 32'h0);
        check("reset_instret", instret, 32'h0);
        RST = 1'b0;
        #1;
        check("first_fetch", {30'd0, bus.mem_req, bus.addr_sel}, 32'h2);

        // name, cyc, rd_we, pcn, pca, n_sub, sub_at, n_rdwe, n_mema, n_memwe
        expect_retire("add",        4, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_ADD,   0, 0, 0);
        expect_retire("sub",        4, 1, 0, 0, 1, 3, 1, 0, 0); run_insn(I_SUB,   0, 0, 0);
        expect_retire("srai",       4, 1, 0, 0, 1, 3, 1, 0, 0); run_insn(I_SRAI,  0, 0, 0);
        expect_retire("addi_b30",   4, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_ADDI,  0, 0, 0);
        expect_retire("lw_wait3",   8, 1, 0, 0, 0, 0, 1, 4, 0); run_insn(I_LW,    0, 0, 3);
        expect_retire("sw",         4, 0, 0, 0, 0, 0, 0, 1, 1); run_insn(I_SW,    0, 0, 0);
        expect_retire("sw_wait2",   6, 0, 0, 0, 0, 0, 0, 3, 3); run_insn(I_SW,    0, 0, 2);
        expect_retire("beq_taken",  3, 0, 0, 1, 0, 0, 0, 0, 0); run_insn(I_BEQ,   1, 0, 0);
        expect_retire("beq_not",    3, 0, 0, 0, 0, 0, 0, 0, 0); run_insn(I_BEQ,   0, 0, 0);
        expect_retire("jalr",       3, 1, 1, 0, 0, 0, 1, 0, 0); run_insn(I_JALR,  0, 0, 0);
        expect_retire("jal",        3, 1, 0, 1, 0, 0, 1, 0, 0); run_insn(I_JAL,   0, 0, 0);
        expect_retire("lui",        4, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_LUI,   0, 0, 0);
        expect_retire("auipc",      4, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_AUIPC, 0, 0, 0);
        expect_retire("add_fwait2", 6, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_ADD,   0, 2, 0);
        expect_retire("fence",      3, 0, 0, 0, 0, 0, 0, 0, 0); run_insn(I_FENCE, 0, 0, 0);
        expect_retire("ecall",      3, 0, 0, 0, 0, 0, 0, 0, 0); run_insn(I_ECALL, 0, 0, 0);

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        INSN = I_BAD;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("illegal_set", {31'd0, illegal}, 32'h1);
        check("illegal_halt_strobes", strobes(), 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        check("illegal_stays_halted", {30'd0, illegal, bus.mem_req}, 32'h2);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_ret = 0;
        #1;
        check("illegal_cleared", {30'd0, illegal, bus.mem_req}, 32'h1);
`else
        expect_retire("unknown_nop", 3, 0, 0, 0, 0, 0, 0, 0, 0); run_insn(I_BAD, 0, 0, 0);
        check("illegal_tied0", {31'd0, illegal}, 32'h0);
`endif

        // Reset while a store is waiting in MEM aborts it.
        INSN = I_SW;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        check("store_pending", {28'd0, bus.mem_req, bus.mem_we, bus.addr_sel, pc_we}, 32'hE);
        RST = 1'b1;
        #1;
        check("rst_outputs_zero", strobes(), 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_ret = 0;
        #1;
        check("post_rst_no_writes", {29'd0, pc_we, rd_we, bus.mem_we}, 32'h0);
        check("post_rst_fetch", {30'd0, bus.mem_req, bus.addr_sel}, 32'h2);
        check("post_rst_instret", instret, 32'h0);
        expect_retire("add_after_rst", 4, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_ADD, 0, 0, 0);

        // Fetch timeout: 255 consecutive not-ready cycles.
        INSN = I_ADD;
        bus.mem_ready = 1'b0;
        repeat (254) @(posedge CLK);
        #1;
        check("timeout_edge_no_fault", {30'd0, fault, bus.mem_req}, 32'h1);
        @(posedge CLK);
        #1;
        check("timeout_fault", {31'd0, fault}, 32'h1);
        check("timeout_strobes", strobes(), 32'h0);
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("halt_ignores_ready", {30'd0, fault, bus.mem_req}, 32'h2);
        RST = 1'b1;
        #1;
        check("fault_low_in_rst", {31'd0, fault}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_ret = 0;
        #1;
        check("fault_cleared_fetch", {30'd0, fault, bus.mem_req}, 32'h1);
        expect_retire("add_after_fault", 4, 1, 0, 0, 0, 0, 1, 0, 0); run_insn(I_ADD, 0, 0, 0);

        repeat (2) @(posedge CLK);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
